pipe_skid_latch: RTL and testbench



---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_skid_latch_sat_counter.sv | 27 ++
 rtl/pipe_skid_latch.sv | 116 +++++++++++
 tb/tb_pipe_skid_latch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid latches: FSM state encoding and the
// occupancy width, plus a helper that maps a state to its entry count.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } latch_state_t;

  function automatic logic [OCC_W-1:0] occ_of(input latch_state_t s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      FULL:    occ = 2'd1;
      SKID:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_latch_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment and
// the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_latch.sv
// Inter-stage pipeline latch with valid/ready handshake, a 2-entry skid buffer,
// branch-redirect flush and a saturating stall-cycle counter.
module pipe_skid_latch
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  latch_state_t     state_q;
  latch_state_t     state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;
  logic             stall_inc;

  assign in_ready  = (state_q != SKID) && !flush;
  assign out_valid = (state_q != EMPTY);
  assign occupancy = occ_of(state_q);
  assign out_data  = main_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush overrides every transition; the data regs are left alone because
  // their contents are don't-care once out_valid drops.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            state_d      = FULL;
            load_main_in = 1'b1;
          end
        end
        FULL: begin
          if (in_valid && out_ready) begin
            load_main_in = 1'b1;
          end else if (!in_valid && out_ready) begin
            state_d = EMPTY;
          end else if (in_valid && !out_ready) begin
            state_d   = SKID;
            load_skid = 1'b1;
          end
        end
        SKID: begin
          if (out_ready) begin
            state_d        = FULL;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Main always holds the older entry; skid only ever holds the younger one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
    end else if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_data;
    end
  end

  assign stall_inc = out_valid && !out_ready && !flush;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (stall_clr),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed checks of pipe_skid_latch followed by a random valid/ready/flush run
// against a queue-based reference model.
module tb_pipe_skid_latch;

  localparam int WIDTH = 37;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_clr;

  int total;
  int bad;

  pipe_skid_latch #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic rdy, input logic fl, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    stall_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the random run
  logic [WIDTH-1:0] mq[$];
  int               m_cnt;
  logic             m_in_ready;
  logic             m_out_valid;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_occ", 64'(occupancy), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    reset = 1'b0;
    step();

    // Streaming at full throughput
    applyStimulus(1'b1, 37'h11, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("stream_v0", 64'(out_valid), 64'd1);
    checkOutput("stream_d0", 64'(out_data), 64'h11);
    checkOutput("stream_occ0", 64'(occupancy), 64'd1);
    applyStimulus(1'b1, 37'h22, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("stream_rdy1", 64'(in_ready), 64'd1);
    step();
    checkOutput("stream_d1", 64'(out_data), 64'h22);
    applyStimulus(1'b1, 37'h33, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("stream_d2", 64'(out_data), 64'h33);
    checkOutput("stream_occ2", 64'(occupancy), 64'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("stream_drain", 64'(out_valid), 64'd0);
    checkOutput("stream_stall", 64'(stall_cnt), 64'd0);

    // Backpressure into the skid entry, then drain in order
    applyStimulus(1'b1, 37'hA, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 37'hB, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("bp_occ", 64'(occupancy), 64'd2);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_out_data", 64'(out_data), 64'hA);
    checkOutput("bp_stall", 64'(stall_cnt), 64'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("bp_second", 64'(out_data), 64'hB);
    checkOutput("bp_occ1", 64'(occupancy), 64'd1);
    step();
    checkOutput("bp_empty", 64'(out_valid), 64'd0);

    // Flush while in SKID squashes both entries and refuses the new one
    applyStimulus(1'b1, 37'hA, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 37'hB, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 37'hC, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("fl_in_ready", 64'(in_ready), 64'd0);
    step();
    checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
    checkOutput("fl_occ", 64'(occupancy), 64'd0);
    checkOutput("fl_stall", 64'(stall_cnt), 64'd2);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("fl_no_c", 64'(out_valid), 64'd0);

    // Stall counter saturates at 15, clear beats increment
    applyStimulus(1'b1, 37'hA, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    checkOutput("sat_cnt", 64'(stall_cnt), 64'd15);
    checkOutput("sat_data", 64'(out_data), 64'hA);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("sat_clr", 64'(stall_cnt), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("sat_after_clr", 64'(stall_cnt), 64'd1);

    // Asynchronous reset between edges while holding two entries
    applyStimulus(1'b1, 37'hB, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("ar_occ_before", 64'(occupancy), 64'd2);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("ar_out_valid", 64'(out_valid), 64'd0);
    checkOutput("ar_in_ready", 64'(in_ready), 64'd1);
    checkOutput("ar_occ", 64'(occupancy), 64'd0);
    checkOutput("ar_out_data", 64'(out_data), 64'd0);
    checkOutput("ar_stall", 64'(stall_cnt), 64'd0);
    step();
    reset = 1'b0;

    // Random valid/ready/flush run against a FIFO model
    mq.delete();
    m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      applyStimulus($urandom_range(99, 0) < 60,
                    WIDTH'({$urandom(), $urandom()}),
                    $urandom_range(99, 0) < 55,
                    $urandom_range(99, 0) < 2,
                    $urandom_range(99, 0) < 1);
      #1;
      m_in_ready  = (mq.size() < 2) && !flush;
      m_out_valid = (mq.size() > 0);
      checkOutput("rnd_in_ready", 64'(in_ready), 64'(m_in_ready));
      checkOutput("rnd_out_valid", 64'(out_valid), 64'(m_out_valid));
      checkOutput("rnd_occ", 64'(occupancy), 64'(mq.size()));
      checkOutput("rnd_stall", 64'(stall_cnt), 64'(m_cnt));
      if (m_out_valid) checkOutput("rnd_out_data", 64'(out_data), 64'(mq[0]));
      @(posedge clk);
      if (stall_clr) m_cnt = 0;
      else if (m_out_valid && !out_ready && !flush && m_cnt < 15) m_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_out_valid && out_ready) void'(mq.pop_front());
        if (in_valid && m_in_ready) mq.push_back(in_data);
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
